// File: rtl/dti_arb_pkg.sv
// rtl/dti_arb_pkg.sv - shared widths, helper function and output word type for the dti arbiter
package dti_arb_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int W_DATA_DEF = 64;
  localparam int N_IN_DEF   = 4;
  localparam int W_IDX_DEF  = idx_width(N_IN_DEF);

  // Arbitrated word at default sizing: winner index above the payload.
  typedef struct packed {
    logic [W_IDX_DEF-1:0]  idx;
    logic [W_DATA_DEF-1:0] payload;
  } dti_arb_word_t;

endpackage

// File: rtl/dti_rr_arbiter_if.sv
// rtl/dti_rr_arbiter_if.sv - dti valid/ready channel with producer and consumer views
interface dti #(
  parameter int W = 64
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dti_rr_arbiter_grant.sv
// rtl/dti_rr_arbiter_grant.sv - combinational wrap-around priority search starting at ptr
module rr_grant #(
  parameter int N_IN  = 4,
  parameter int W_IDX = 2
) (
  input  logic [N_IN-1:0]  req,
  input  logic [W_IDX-1:0] ptr,
  output logic [N_IN-1:0]  grant,
  output logic [W_IDX-1:0] idx,
  output logic             any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N_IN; k++) begin
      j = int'(ptr) + k;
      if (j >= N_IN) j = j - N_IN;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = W_IDX'(j);
      end
    end
  end

endmodule

// File: rtl/dti_rr_arbiter.sv
// rtl/dti_rr_arbiter.sv - N_IN-to-1 round-robin dti arbiter with optional packet lock
// and a registered output tagged with the winning input index.
module dti_rr_arbiter
  import dti_arb_pkg::*;
#(
  parameter int W_DATA      = 64,
  parameter int N_IN        = 4,
  parameter bit LOCK_ON_EOT = 1'b1,
  parameter int W_IDX       = idx_width(N_IN)
) (
  input  logic clk,
  input  logic rst,
  dti.slave    din [N_IN],
  dti.master   dout
);

  typedef struct packed {
    logic [W_IDX-1:0]  idx;
    logic [W_DATA-1:0] payload;
  } out_word_t;

  logic [N_IN-1:0]   vld;
  logic [W_DATA-1:0] pdata [N_IN];
  logic [N_IN-1:0]   rdy;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    assign vld[i]       = din[i].valid;
    assign pdata[i]     = din[i].data;
    assign din[i].ready = rdy[i];
  end

  logic [W_IDX-1:0] ptr_q;
  logic [W_IDX-1:0] lock_idx_q;
  logic             locked_q;
  logic             valid_q;
  out_word_t        data_q;

  logic [N_IN-1:0]   req;
  logic [N_IN-1:0]   grant;
  logic [W_IDX-1:0]  gidx;
  logic              gany;
  logic              load;
  logic              xfer;
  logic              eot;
  logic [W_DATA-1:0] sel;

  // While locked only the owning input may request, so the search returns it or nothing.
  always_comb begin
    req = '0;
    for (int i = 0; i < N_IN; i++)
      req[i] = vld[i] && (!locked_q || (lock_idx_q == W_IDX'(i)));
  end

  rr_grant #(
    .N_IN  (N_IN),
    .W_IDX (W_IDX)
  ) u_grant (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign load = !valid_q || dout.ready;
  assign rdy  = (rst && load) ? grant : '0;
  assign xfer = rst && load && gany;
  assign sel  = pdata[gidx];
  assign eot  = LOCK_ON_EOT ? sel[W_DATA-1] : 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      ptr_q      <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else if (load) begin
      valid_q <= xfer;
      if (xfer) begin
        data_q <= '{idx: gidx, payload: sel};
        if (eot) begin
          locked_q <= 1'b0;
          ptr_q    <= (gidx == W_IDX'(N_IN - 1)) ? '0 : gidx + W_IDX'(1);
        end else begin
          locked_q   <= 1'b1;
          lock_idx_q <= gidx;
        end
      end
    end
  end

  assign dout.valid = valid_q;
  assign dout.data  = data_q;

endmodule

// File: tb/tb_dti_rr_arbiter.sv
// tb/tb_dti_rr_arbiter.sv - directed self-checking bench for dti_rr_arbiter
module tb_dti_rr_arbiter;

  logic clk;
  logic rst;
  logic [63:0] d [4];
  logic        v [4];
  logic [3:0]  r;
  logic        dout_ready;

  int vectors;
  int miscompares;

  dti #(.W(64)) din [4] ();
  dti #(.W(66)) dout ();

  for (genvar i = 0; i < 4; i++) begin : g_ch
    assign din[i].data  = d[i];
    assign din[i].valid = v[i];
    assign r[i]         = din[i].ready;
  end
  assign dout.ready = dout_ready;

  dti_rr_arbiter #(
    .W_DATA      (64),
    .N_IN        (4),
    .LOCK_ON_EOT (1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input bit e, input logic [7:0] tag);
    return {e, 55'd0, tag};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] idx, input logic [63:0] payload);
    chk({tag, ".valid"}, {65'd0, dout.valid}, 66'd1);
    chk({tag, ".data"}, dout.data, {idx, payload});
  endtask

  task automatic set_all(input logic val);
    for (int i = 0; i < 4; i++) v[i] = val;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    dout_ready  = 1'b1;
    set_all(1'b0);
    for (int i = 0; i < 4; i++) d[i] = mk(1'b1, 8'(i));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.valid", {65'd0, dout.valid}, 66'd0);
    chk("rst.data", dout.data, 66'd0);
    set_all(1'b1);
    #1;
    chk("rst.ready", {62'd0, r}, 66'h0);

    // fairness: all request, all eot
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("fair.ready0", {62'd0, r}, 66'h1);
    chk("fair.bubble0", {65'd0, dout.valid}, 66'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      chk_out("fair.out", 2'((k - 1) % 4), d[(k - 1) % 4]);
      chk("fair.ready", {62'd0, r}, {62'd0, 4'(1 << (k % 4))});
    end
    set_all(1'b0);

    // packet lock: din[1] 3-word packet while din[2] waits
    @(negedge clk);
    #1;
    chk("lock.idle", {65'd0, dout.valid}, 66'd0);
    v[1] = 1'b1; d[1] = mk(1'b0, 8'h11);
    v[2] = 1'b1; d[2] = mk(1'b1, 8'h21);
    #1;
    chk("lock.ready1", {62'd0, r}, 66'h2);
    @(negedge clk);
    #1;
    chk_out("lock.w1", 2'd1, mk(1'b0, 8'h11));
    d[1] = mk(1'b0, 8'h12);
    #1;
    chk("lock.ready2", {62'd0, r}, 66'h2);
    @(negedge clk);
    #1;
    chk_out("lock.w2", 2'd1, mk(1'b0, 8'h12));
    d[1] = mk(1'b1, 8'h13);
    #1;
    chk("lock.ready3", {62'd0, r}, 66'h2);
    @(negedge clk);
    #1;
    chk_out("lock.w3", 2'd1, mk(1'b1, 8'h13));
    v[1] = 1'b0;
    #1;
    chk("lock.ready_next", {62'd0, r}, 66'h4);
    @(negedge clk);
    #1;
    chk_out("lock.next", 2'd2, mk(1'b1, 8'h21));
    v[2] = 1'b0;
    #1;
    chk("lock.ready_none", {62'd0, r}, 66'h0);

    // backpressure: ptr is 3 here
    @(negedge clk);
    v[3] = 1'b1; d[3] = mk(1'b1, 8'h31);
    v[0] = 1'b1; d[0] = mk(1'b1, 8'h01);
    #1;
    chk("bp.ready_pre", {62'd0, r}, 66'h8);
    @(negedge clk);
    #1;
    chk_out("bp.first", 2'd3, mk(1'b1, 8'h31));
    v[3] = 1'b0;
    dout_ready = 1'b0;
    #1;
    chk("bp.ready_stall", {62'd0, r}, 66'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk_out("bp.hold", 2'd3, mk(1'b1, 8'h31));
      chk("bp.ready_hold", {62'd0, r}, 66'h0);
    end
    dout_ready = 1'b1;
    #1;
    chk("bp.ready_resume", {62'd0, r}, 66'h1);
    @(negedge clk);
    #1;
    chk_out("bp.resume", 2'd0, mk(1'b1, 8'h01));
    v[0] = 1'b0;
    #1;
    chk("bp.ready_after", {62'd0, r}, 66'h0);
    @(negedge clk);
    #1;
    chk("bp.drain", {65'd0, dout.valid}, 66'd0);

    // lock gap: ptr is 1; din[3] locks then drops valid
    v[3] = 1'b1; d[3] = mk(1'b0, 8'h32);
    v[0] = 1'b1; d[0] = mk(1'b1, 8'h02);
    #1;
    chk("gap.ready_pre", {62'd0, r}, 66'h8);
    @(negedge clk);
    #1;
    chk_out("gap.w1", 2'd3, mk(1'b0, 8'h32));
    v[3] = 1'b0;
    #1;
    chk("gap.ready_gap", {62'd0, r}, 66'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("gap.bubble", {65'd0, dout.valid}, 66'd0);
      chk("gap.starve", {62'd0, r}, 66'h0);
    end
    v[3] = 1'b1; d[3] = mk(1'b1, 8'h33);
    #1;
    chk("gap.ready_eot", {62'd0, r}, 66'h8);
    @(negedge clk);
    #1;
    chk_out("gap.eot", 2'd3, mk(1'b1, 8'h33));
    v[3] = 1'b0;
    #1;
    chk("gap.ready_release", {62'd0, r}, 66'h1);
    @(negedge clk);
    #1;
    chk_out("gap.other", 2'd0, mk(1'b1, 8'h02));
    v[0] = 1'b0;

    // sparse: only din[2], ptr moves to 3 then wraps back to 2
    v[2] = 1'b1; d[2] = mk(1'b1, 8'h22);
    #1;
    chk("sparse.ready_a", {62'd0, r}, 66'h4);
    @(negedge clk);
    #1;
    chk_out("sparse.a", 2'd2, mk(1'b1, 8'h22));
    d[2] = mk(1'b1, 8'h23);
    #1;
    chk("sparse.ready_wrap", {62'd0, r}, 66'h4);
    @(negedge clk);
    #1;
    chk_out("sparse.wrap", 2'd2, mk(1'b1, 8'h23));
    set_all(1'b1);
    d[3] = mk(1'b0, 8'h34);
    #1;
    chk("sparse.ptr3", {62'd0, r}, 66'h8);

    // reset mid-packet: din[3] holds a lock when reset hits
    @(negedge clk);
    #1;
    chk_out("mid.locked", 2'd3, mk(1'b0, 8'h34));
    rst = 1'b0;
    #1;
    chk("mid.rst_valid", {65'd0, dout.valid}, 66'd0);
    chk("mid.rst_data", dout.data, 66'd0);
    chk("mid.rst_ready", {62'd0, r}, 66'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid.ready_first", {62'd0, r}, 66'h1);
    @(negedge clk);
    #1;
    chk_out("mid.first", 2'd0, mk(1'b1, 8'h02));
    chk("mid.ready_second", {62'd0, r}, 66'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
